branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Execute-stage counterpart of the fetch-stage branch predictor.
- Carries each fetch-time prediction (taken flag, predicted target) through the F->D and D->E pipeline registers.
- In Execute, compares the prediction with the actual outcome and raises a misprediction redirect to the PC mux and hazard unit.
- Drives the predictor update interface: PCE, PCTargetE, BranchTakenE and an update strobe.

Parameters:
- DATA_WIDTH, 32, PC/target width.
- CNT_WIDTH, 32, performance counter width (only used with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ValidF  in  1  fetched instruction valid
- PredictTakenF  in  1  predictor taken flag for PCF
- PredictedTargetF  in  DATA_WIDTH  predictor target for PCF
- StallD  in  1  hold F->D register
- FlushD  in  1  clear F->D register
- FlushE  in  1  clear D->E register
- PCE  in  DATA_WIDTH  PC of instruction in Execute
- PCTargetE  in  DATA_WIDTH  computed branch/jump target
- BranchE  in  1  Execute instruction is conditional branch
- JumpE  in  1  Execute instruction is JAL/JALR
- BranchCondE  in  1  ALU branch condition true
- BranchTakenE  out  1  actual taken outcome, to predictor
- UpdateE  out  1  predictor update strobe (predictor's BranchE)
- MispredictE  out  1  redirect request
- RedirectPCE  out  DATA_WIDTH  corrected fetch PC
- BranchCountO  out  CNT_WIDTH  resolved branch/jump count (optional)
- MispredCountO  out  CNT_WIDTH  misprediction count (optional)

Behaviour:
- Two metadata registers, D and E, each holding {valid, pred_taken, pred_target}. Reset value is all zeros.
- D register update priority: rst > FlushD (clear) > StallD (hold) > load {ValidF, PredictTakenF, PredictedTargetF}.
- E register update priority: rst > FlushE (clear) > load D contents. There is no E stall; the hazard unit flushes E instead.
- Latency: a prediction presented in F is evaluated two clock edges later, when the instruction reaches E.
- Outputs are combinational from the E register plus Execute inputs:
  - ActE = validE & (BranchE | JumpE).
  - BranchTakenE = ActE & (JumpE | BranchCondE).
  - UpdateE = ActE.
  - MispredictE is high in any of these cases:
    - ActE & BranchTakenE & (!pred_takenE | pred_targetE != PCTargetE), giving RedirectPCE = PCTargetE.
    - ActE & !BranchTakenE & pred_takenE, giving RedirectPCE = PCE + 4.
    - validE & !(BranchE | JumpE) & pred_takenE (stale BTB hit on a non-branch), giving RedirectPCE = PCE + 4.
  - Otherwise MispredictE = 0 and RedirectPCE = PCE + 4 (don't-care).
- PCE + 4 wraps modulo 2^DATA_WIDTH.
- Invalid (bubble) E entry: all outputs 0; no update, no redirect.
- Same-cycle MispredictE and FlushE: the current-cycle outputs stand; E is cleared at the next edge.
- FlushD and StallD together: flush wins.
- Reset mid-operation: both registers clear at the edge; outputs read 0 in the following cycle regardless of Execute inputs.

Optional Feature:
- Macro: BRU_PERF_CNT_EN.
- When defined:
  - BranchCountO increments on every UpdateE cycle.
  - MispredCountO increments on every MispredictE cycle.
  - Both saturate at all-ones and clear on rst.
- When undefined: both outputs are tied to 0 and no counter flops exist.

Decomposition:
- Shared package bp_pkg holds:
  - typedef bp_meta_t = struct {valid, pred_taken, pred_target[DATA_WIDTH-1:0]}.
  - localparam PC_INCR = 4.
- Sub-module bp_meta_reg: a bp_meta_t pipeline register with stall/flush inputs, instantiated for D (stall tied per StallD) and E (stall tied 0).

Test Plan:
- Reset, then ValidF=1 with no branch → UpdateE=0, MispredictE=0; counters stay 0.
- F: PredictTakenF=1, target 0x100. Two edges later: BranchE=1, BranchCondE=1, PCTargetE=0x100 → UpdateE=1, BranchTakenE=1, MispredictE=0.
- Predicted taken to 0x100, actual not taken, PCE=0x40 → MispredictE=1, RedirectPCE=0x44, BranchTakenE=0.
- Predicted not taken, JumpE=1, PCTargetE=0x200 → MispredictE=1, RedirectPCE=0x200. Repeat with predicted target 0x204 → MispredictE=1 (target mismatch).
- StallD=1 for 3 cycles then FlushE=1 → the held prediction reaches E exactly once; the flushed slot gives all-zero outputs. FlushD and StallD together → D cleared.
- With BRU_PERF_CNT_EN and CNT_WIDTH=4:
  - 17 mispredicted branches → BranchCountO = MispredCountO = 15 (saturated).
  - rst → both 0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types for the branch prediction path: per-instruction prediction metadata
// and the sequential fetch increment.
package bp_pkg;

  localparam int BP_DATA_WIDTH = 32;
  localparam int PC_INCR       = 4;

  typedef struct packed {
    logic                     valid;
    logic                     pred_taken;
    logic [BP_DATA_WIDTH-1:0] pred_target;
  } bp_meta_t;

endpackage

// File: rtl/bp_meta_reg.sv
// One pipeline stage of prediction metadata; reset beats flush, and flush beats stall.
module bp_meta_reg
  import bp_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     stall,
  input  logic     flush,
  input  bp_meta_t meta_i,
  output bp_meta_t meta_o
);

  bp_meta_t meta_d, meta_q;

  always_comb begin
    meta_d = meta_q;
    if (flush) begin
      meta_d = '0;
    end else if (!stall) begin
      meta_d = meta_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
    end else begin
      meta_q <= meta_d;
    end
  end

  assign meta_o = meta_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: checks the fetch-time prediction against the real outcome.
// Optional saturating performance counters are built when BRU_PERF_CNT_EN is defined.
module branch_resolve_unit
  import bp_pkg::*;
#(
  parameter int DATA_WIDTH = BP_DATA_WIDTH,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ValidF,
  input  logic                  PredictTakenF,
  input  logic [DATA_WIDTH-1:0] PredictedTargetF,
  input  logic                  StallD,
  input  logic                  FlushD,
  input  logic                  FlushE,
  input  logic [DATA_WIDTH-1:0] PCE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  input  logic                  BranchE,
  input  logic                  JumpE,
  input  logic                  BranchCondE,
  output logic                  BranchTakenE,
  output logic                  UpdateE,
  output logic                  MispredictE,
  output logic [DATA_WIDTH-1:0] RedirectPCE,
  output logic [CNT_WIDTH-1:0]  BranchCountO,
  output logic [CNT_WIDTH-1:0]  MispredCountO
);

  bp_meta_t meta_f, meta_d, meta_e;
  logic     act_e;
  logic [DATA_WIDTH-1:0] fallthrough_e;

  assign meta_f.valid       = ValidF;
  assign meta_f.pred_taken  = PredictTakenF;
  assign meta_f.pred_target = PredictedTargetF;

  bp_meta_reg u_meta_d (
    .clk    (clk),
    .rst    (rst),
    .stall  (StallD),
    .flush  (FlushD),
    .meta_i (meta_f),
    .meta_o (meta_d)
  );

  // E never stalls: the hazard unit bubbles it with FlushE instead.
  bp_meta_reg u_meta_e (
    .clk    (clk),
    .rst    (rst),
    .stall  (1'b0),
    .flush  (FlushE),
    .meta_i (meta_d),
    .meta_o (meta_e)
  );

  // A bubble in E drives every output low, including the redirect PC.
  always_comb begin
    act_e         = meta_e.valid & (BranchE | JumpE);
    fallthrough_e = PCE + DATA_WIDTH'(PC_INCR);
    BranchTakenE  = act_e & (JumpE | BranchCondE);
    UpdateE       = act_e;
    MispredictE   = 1'b0;
    RedirectPCE   = '0;
    if (meta_e.valid) begin
      RedirectPCE = fallthrough_e;
      if (BranchTakenE) begin
        if (!meta_e.pred_taken || (meta_e.pred_target != PCTargetE)) begin
          MispredictE = 1'b1;
          RedirectPCE = PCTargetE;
        end
      end else if (meta_e.pred_taken) begin
        MispredictE = 1'b1;
      end
    end
  end

`ifdef BRU_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] branch_cnt_d, branch_cnt_q;
  logic [CNT_WIDTH-1:0] mispred_cnt_d, mispred_cnt_q;

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (UpdateE && !(&branch_cnt_q)) begin
      branch_cnt_d = branch_cnt_q + 1'b1;
    end
    if (MispredictE && !(&mispred_cnt_q)) begin
      mispred_cnt_d = mispred_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign BranchCountO  = branch_cnt_q;
  assign MispredCountO = mispred_cnt_q;
`else
  assign BranchCountO  = '0;
  assign MispredCountO = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a two-slot prediction pipeline model checked every
// cycle, plus literal expectations per scenario. Counter checks follow BRU_PERF_CNT_EN.
module tb_branch_resolve_unit;

  localparam int DW    = 32;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ValidF = 1'b0;
  logic          PredictTakenF = 1'b0;
  logic [DW-1:0] PredictedTargetF = '0;
  logic          StallD = 1'b0;
  logic          FlushD = 1'b0;
  logic          FlushE = 1'b0;
  logic [DW-1:0] PCE = '0;
  logic [DW-1:0] PCTargetE = '0;
  logic          BranchE = 1'b0;
  logic          JumpE = 1'b0;
  logic          BranchCondE = 1'b0;
  logic          BranchTakenE;
  logic          UpdateE;
  logic          MispredictE;
  logic [DW-1:0] RedirectPCE;
  logic [CW-1:0] BranchCountO;
  logic [CW-1:0] MispredCountO;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  branch_resolve_unit #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .ValidF           (ValidF),
    .PredictTakenF    (PredictTakenF),
    .PredictedTargetF (PredictedTargetF),
    .StallD           (StallD),
    .FlushD           (FlushD),
    .FlushE           (FlushE),
    .PCE              (PCE),
    .PCTargetE        (PCTargetE),
    .BranchE          (BranchE),
    .JumpE            (JumpE),
    .BranchCondE      (BranchCondE),
    .BranchTakenE     (BranchTakenE),
    .UpdateE          (UpdateE),
    .MispredictE      (MispredictE),
    .RedirectPCE      (RedirectPCE),
    .BranchCountO     (BranchCountO),
    .MispredCountO    (MispredCountO)
  );

  always #5 clk = ~clk;

  // Model: slot 0 is the Decode copy of a prediction, slot 1 the Execute copy.
  logic          m_valid [2] = '{1'b0, 1'b0};
  logic          m_taken [2] = '{1'b0, 1'b0};
  logic [DW-1:0] m_tgt   [2] = '{32'h0, 32'h0};
  int            m_bcnt = 0;
  int            m_mcnt = 0;

  logic          exp_act, exp_taken, exp_mis;
  logic [DW-1:0] exp_redirect;

  always @* begin
    exp_act   = m_valid[1] && (BranchE || JumpE);
    exp_taken = exp_act && (JumpE || BranchCondE);
    exp_mis   = (exp_taken && (!m_taken[1] || m_tgt[1] != PCTargetE))
             || (exp_act && !exp_taken && m_taken[1])
             || (m_valid[1] && !(BranchE || JumpE) && m_taken[1]);
    if (!m_valid[1])
      exp_redirect = '0;
    else if (exp_mis && exp_taken)
      exp_redirect = PCTargetE;
    else
      exp_redirect = PCE + 32'd4;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= '{1'b0, 1'b0};
      m_taken <= '{1'b0, 1'b0};
      m_tgt   <= '{32'h0, 32'h0};
      m_bcnt  <= 0;
      m_mcnt  <= 0;
    end else begin
      m_valid[1] <= FlushE ? 1'b0 : m_valid[0];
      m_taken[1] <= FlushE ? 1'b0 : m_taken[0];
      m_tgt[1]   <= FlushE ? '0   : m_tgt[0];
      if (FlushD) begin
        m_valid[0] <= 1'b0;
        m_taken[0] <= 1'b0;
        m_tgt[0]   <= '0;
      end else if (!StallD) begin
        m_valid[0] <= ValidF;
        m_taken[0] <= PredictTakenF;
        m_tgt[0]   <= PredictedTargetF;
      end
`ifdef BRU_PERF_CNT_EN
      if (exp_act && m_bcnt < CMAX) m_bcnt <= m_bcnt + 1;
      if (exp_mis && m_mcnt < CMAX) m_mcnt <= m_mcnt + 1;
`endif
    end
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, required, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("model.BranchTakenE", {31'b0, BranchTakenE}, {31'b0, exp_taken});
      checkOutput("model.UpdateE", {31'b0, UpdateE}, {31'b0, exp_act});
      checkOutput("model.MispredictE", {31'b0, MispredictE}, {31'b0, exp_mis});
      checkOutput("model.RedirectPCE", RedirectPCE, exp_redirect);
      checkOutput("model.BranchCountO", {28'b0, BranchCountO}, m_bcnt[DW-1:0]);
      checkOutput("model.MispredCountO", {28'b0, MispredCountO}, m_mcnt[DW-1:0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setExec(input logic [DW-1:0] pce, input logic [DW-1:0] pct,
                         input logic br, input logic jmp, input logic cond);
    PCE = pce; PCTargetE = pct; BranchE = br; JumpE = jmp; BranchCondE = cond;
  endtask

  // Issue one prediction in F, then present its Execute inputs two edges later.
  task automatic applyStimulus(input logic v, input logic pt, input logic [DW-1:0] tgt,
                               input logic [DW-1:0] pce, input logic [DW-1:0] pct,
                               input logic br, input logic jmp, input logic cond);
    tick();
    ValidF = v; PredictTakenF = pt; PredictedTargetF = tgt;
    setExec('0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    ValidF = 1'b0; PredictTakenF = 1'b0; PredictedTargetF = '0;
    tick();
    setExec(pce, pct, br, jmp, cond);
    @(negedge clk);
  endtask

  task automatic checkLit(input string name, input logic taken, input logic upd,
                          input logic mis, input logic [DW-1:0] redir);
    checkOutput({name, ".taken"}, {31'b0, BranchTakenE}, {31'b0, taken});
    checkOutput({name, ".update"}, {31'b0, UpdateE}, {31'b0, upd});
    checkOutput({name, ".mispredict"}, {31'b0, MispredictE}, {31'b0, mis});
    checkOutput({name, ".redirect"}, RedirectPCE, redir);
  endtask

  initial begin
    logic [DW-1:0] sat_exp;
`ifdef BRU_PERF_CNT_EN
    sat_exp = 32'd15;
`else
    sat_exp = 32'd0;
`endif
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkLit("reset", 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("reset.bcnt", {28'b0, BranchCountO}, 32'h0);

    applyStimulus(1'b1, 1'b0, 32'h0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    checkLit("nobranch", 1'b0, 1'b0, 1'b0, 32'h14);
    checkOutput("nobranch.mcnt", {28'b0, MispredCountO}, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h100, 32'h20, 32'h100, 1'b1, 1'b0, 1'b1);
    checkLit("correct_taken", 1'b1, 1'b1, 1'b0, 32'h24);
    applyStimulus(1'b1, 1'b1, 32'h100, 32'h40, 32'h100, 1'b1, 1'b0, 1'b0);
    checkLit("pred_t_not_taken", 1'b0, 1'b1, 1'b1, 32'h44);
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h50, 32'h200, 1'b0, 1'b1, 1'b0);
    checkLit("jump_pred_nt", 1'b1, 1'b1, 1'b1, 32'h200);
    applyStimulus(1'b1, 1'b1, 32'h204, 32'h50, 32'h200, 1'b0, 1'b1, 1'b0);
    checkLit("jump_tgt_mismatch", 1'b1, 1'b1, 1'b1, 32'h200);
    applyStimulus(1'b1, 1'b1, 32'h300, 32'h60, 32'h0, 1'b0, 1'b0, 1'b0);
    checkLit("stale_btb", 1'b0, 1'b0, 1'b1, 32'h64);
    applyStimulus(1'b1, 1'b1, 32'h8, 32'hFFFF_FFFC, 32'h8, 1'b1, 1'b0, 1'b0);
    checkLit("pc_wrap", 1'b0, 1'b1, 1'b1, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h100, 32'h70, 32'h200, 1'b1, 1'b0, 1'b1);
    checkLit("bubble", 1'b0, 1'b0, 1'b0, 32'h0);

    // Load-use style stall: D holds while E is bubbled, then the held entry passes once.
    tick();
    ValidF = 1'b1; PredictTakenF = 1'b1; PredictedTargetF = 32'h300;
    setExec('0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    ValidF = 1'b0; PredictTakenF = 1'b0; PredictedTargetF = '0;
    StallD = 1'b1; FlushE = 1'b1;
    setExec(32'h90, 32'h300, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      checkLit("stall_bubble", 1'b0, 1'b0, 1'b0, 32'h0);
    end
    StallD = 1'b0; FlushE = 1'b0;
    tick();
    @(negedge clk);
    checkLit("stall_release", 1'b1, 1'b1, 1'b0, 32'h94);
    tick();
    @(negedge clk);
    checkLit("stall_once", 1'b0, 1'b0, 1'b0, 32'h0);

    // FlushD together with StallD clears D.
    tick();
    ValidF = 1'b1; PredictTakenF = 1'b1; PredictedTargetF = 32'h400;
    setExec('0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    ValidF = 1'b0; PredictTakenF = 1'b0; PredictedTargetF = '0;
    StallD = 1'b1; FlushD = 1'b1;
    tick();
    StallD = 1'b0; FlushD = 1'b0;
    setExec(32'hA0, 32'h404, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checkLit("flush_stall_inflight", 1'b1, 1'b1, 1'b1, 32'h404);
    tick();
    @(negedge clk);
    checkLit("flush_stall_cleared", 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset while a valid branch sits in E.
    applyStimulus(1'b1, 1'b1, 32'h500, 32'hB0, 32'h500, 1'b1, 1'b0, 1'b1);
    checkLit("pre_reset", 1'b1, 1'b1, 1'b0, 32'hB4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkLit("mid_reset", 1'b0, 1'b0, 1'b0, 32'h0);

    // Seventeen back-to-back mispredicted branches drive the counters to saturation.
    tick();
    ValidF = 1'b1; PredictTakenF = 1'b0; PredictedTargetF = '0;
    setExec(32'h70, 32'h80, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i < 17; i++) tick();
    tick();
    ValidF = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    @(negedge clk);
    checkOutput("sat.bcnt", {28'b0, BranchCountO}, sat_exp);
    checkOutput("sat.mcnt", {28'b0, MispredCountO}, sat_exp);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    setExec('0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("cnt_reset.bcnt", {28'b0, BranchCountO}, 32'h0);
    checkOutput("cnt_reset.mcnt", {28'b0, MispredCountO}, 32'h0);

    tick();
    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
